// File: rtl/cache_stall_arb.sv
// ---------------------------------------------------------------------------
// cache_stall_arb
//   Arbitrates cache access among NPORT CPU-side requesters and tracks cache
//   busy. Forced ports win outright, normal requests are served round-robin,
//   a stalled request escapes after STALL_MAX cycles (timeout), and a port
//   may withdraw its request while stalled.
//
// Parameters
//   NPORT           number of requesting ports (>= 2)
//   STALL_MAX       max consecutive STALL cycles before forced enable; 0 = off
//
// Ports
//   clk             clock, all state changes on rising edge
//   rst_n           asynchronous active-low reset
//   i_cpu_req       per-port request, held until granted with enable
//   i_cpu_force     per-port force, takes the cache regardless of busy
//   i_cache_busy_n  cache ready (1) / busy (0)
//   o_cache_enable  registered cache access strobe for the granted port
//   o_grant         registered one-hot owner, zero when idle
//   o_grant_idx     binary index of o_grant, zero when o_grant is zero
//   o_stall_timeout registered pulse in the OWN cycle entered by timeout
// ---------------------------------------------------------------------------
module cache_stall_arb #(
    parameter int NPORT     = 2,
    parameter int STALL_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORT-1:0]         i_cpu_req,
    input  logic [NPORT-1:0]         i_cpu_force,
    input  logic                     i_cache_busy_n,
    output logic                     o_cache_enable,
    output logic [NPORT-1:0]         o_grant,
    output logic [$clog2(NPORT)-1:0] o_grant_idx,
    output logic                     o_stall_timeout
);

    localparam int IDX_W      = $clog2(NPORT);
    localparam int CNT_W      = $clog2(STALL_MAX) + 1;
    localparam int CNT_LAST_I = (STALL_MAX > 0) ? STALL_MAX - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_OWN
    } state_t;

    state_t             r_state;
    logic [NPORT-1:0]   r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_cache_enable;
    logic               r_stall_timeout;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_any_force;
    logic [IDX_W-1:0]   w_force_idx;
    logic               w_any_req;
    logic [IDX_W-1:0]   w_rr_idx;
    logic [IDX_W-1:0]   w_ptr;
    logic [IDX_W-1:0]   w_cand;
    logic               w_req_held;

    state_t             w_arb_state;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [NPORT-1:0]   w_arb_grant;
    logic               w_arb_en;

    // Lowest-index forced port.
    always_comb begin
        w_any_force = 1'b0;
        w_force_idx = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (i_cpu_force[i] && !w_any_force) begin
                w_any_force = 1'b1;
                w_force_idx = IDX_W'(i);
            end
        end
    end

    // While in OWN the pointer update to grant_idx lands at this same edge,
    // so the search starts from the current owner rather than the stale
    // stored pointer; this is what lets back-to-back grants alternate.
    assign w_ptr = (r_state == S_OWN) ? r_grant_idx : r_rr_ptr;

    // First requesting port strictly after w_ptr, wrapping.
    always_comb begin
        w_any_req = 1'b0;
        w_rr_idx  = '0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            w_cand = IDX_W'((32'(w_ptr) + k) % NPORT);
            if (i_cpu_req[w_cand] && !w_any_req) begin
                w_any_req = 1'b1;
                w_rr_idx  = w_cand;
            end
        end
    end

    // Arbitration result used from IDLE, OWN, preemption and withdrawal.
    always_comb begin
        w_arb_state = S_IDLE;
        w_arb_idx   = '0;
        w_arb_en    = 1'b0;
        if (w_any_force) begin
            w_arb_state = S_OWN;
            w_arb_idx   = w_force_idx;
            w_arb_en    = 1'b1;
        end else if (w_any_req) begin
            w_arb_idx   = w_rr_idx;
            w_arb_en    = i_cache_busy_n;
            w_arb_state = i_cache_busy_n ? S_OWN : S_STALL;
        end
        w_arb_grant = (w_arb_state == S_IDLE) ? '0 : (NPORT'(1) << w_arb_idx);
    end

    assign w_req_held = i_cpu_req[r_grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_grant_idx     <= '0;
            r_cache_enable  <= 1'b0;
            r_stall_timeout <= 1'b0;
            r_rr_ptr        <= IDX_W'(NPORT - 1);
            r_stall_cnt     <= '0;
        end else begin
            r_stall_timeout <= 1'b0;
            if (r_state == S_OWN) begin
                r_rr_ptr <= r_grant_idx;
            end
            // STALL folds force preemption and withdrawal into the same
            // arbitration path as IDLE/OWN; the stored pointer is untouched
            // there, so a preempted port stays next-in-line.
            if (r_state != S_STALL || w_any_force || !w_req_held) begin
                r_state        <= w_arb_state;
                r_grant        <= w_arb_grant;
                r_grant_idx    <= w_arb_idx;
                r_cache_enable <= w_arb_en;
                r_stall_cnt    <= '0;
            end else if (i_cache_busy_n) begin
                r_state        <= S_OWN;
                r_cache_enable <= 1'b1;
            end else if (STALL_MAX != 0 && r_stall_cnt == CNT_LAST) begin
                r_state         <= S_OWN;
                r_cache_enable  <= 1'b1;
                r_stall_timeout <= 1'b1;
            end else if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cache_enable  = r_cache_enable;
    assign o_grant         = r_grant;
    assign o_grant_idx     = r_grant_idx;
    assign o_stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_cache_stall_arb.sv
// ---------------------------------------------------------------------------
// tb_cache_stall_arb
//   Directed bench for cache_stall_arb (NPORT=2, STALL_MAX=8). A
//   transaction-level model (owner, waiting, cycles waited, last served)
//   predicts the outputs and is compared on every falling edge; literal
//   expectations after each directed step pin the model.
// ---------------------------------------------------------------------------
module tb_cache_stall_arb;

    localparam int NPORT     = 2;
    localparam int STALL_MAX = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NPORT-1:0] cpu_req = '0;
    logic [NPORT-1:0] cpu_force = '0;
    logic             busy_n = 1'b1;
    logic             cache_enable;
    logic [NPORT-1:0] grant;
    logic [0:0]       grant_idx;
    logic             stall_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    cache_stall_arb #(
        .NPORT    (NPORT),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cpu_req      (cpu_req),
        .i_cpu_force    (cpu_force),
        .i_cache_busy_n (busy_n),
        .o_cache_enable (cache_enable),
        .o_grant        (grant),
        .o_grant_idx    (grant_idx),
        .o_stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int m_owner;    // -1 = nobody
    bit m_waiting;  // owner waits for the cache
    int m_waited;   // stall cycles spent so far, including the current one
    int m_last;     // last port that actually accessed the cache
    bit m_en;
    bit m_to;
    int m_f;
    int m_nxt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_waiting = 0; m_waited = 0;
            m_last = NPORT - 1; m_en = 0; m_to = 0;
        end else begin
            if (m_en) m_last = m_owner;
            m_f = -1;
            for (int i = 0; i < NPORT; i++)
                if (cpu_force[i] && m_f < 0) m_f = i;
            m_to = 0;
            if (m_waiting && m_f < 0 && cpu_req[m_owner]) begin
                if (busy_n) begin
                    m_waiting = 0; m_en = 1;
                end else if (STALL_MAX != 0 && m_waited == STALL_MAX) begin
                    m_waiting = 0; m_en = 1; m_to = 1;
                end else begin
                    m_waited++;
                end
            end else if (m_f >= 0) begin
                m_owner = m_f; m_waiting = 0; m_en = 1;
            end else begin
                m_nxt = -1;
                for (int k = 1; k <= NPORT; k++)
                    if (m_nxt < 0 && cpu_req[(m_last + k) % NPORT]) m_nxt = (m_last + k) % NPORT;
                if (m_nxt < 0) begin
                    m_owner = -1; m_waiting = 0; m_en = 0;
                end else begin
                    m_owner = m_nxt;
                    m_en = busy_n;
                    m_waiting = !busy_n;
                    m_waited = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NPORT-1:0] e_grant;
    logic [0:0]       e_idx;

    always @(negedge clk) begin
        if (chk_on) begin
            e_grant = (m_owner < 0) ? '0 : (NPORT'(1) << m_owner);
            e_idx   = (m_owner < 0) ? 1'b0 : 1'(m_owner);
            n_tests++;
            if (cache_enable !== m_en || grant !== e_grant || grant_idx !== e_idx ||
                stall_timeout !== m_to) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got en=%b grant=%b idx=%b to=%b want en=%b grant=%b idx=%b to=%b",
                         $time, cache_enable, grant, grant_idx, stall_timeout,
                         m_en, e_grant, e_idx, m_to);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input logic [1:0] rq, input logic [1:0] fc, input logic bn);
        cpu_req = rq; cpu_force = fc; busy_n = bn;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic en, input logic [1:0] gr,
                       input logic idx, input logic to);
        n_tests++;
        if (cache_enable !== en || grant !== gr || grant_idx !== idx || stall_timeout !== to) begin
            n_fail++;
            $display("FAIL %s got en=%b grant=%b idx=%b to=%b want en=%b grant=%b idx=%b to=%b",
                     nm, cache_enable, grant, grant_idx, stall_timeout, en, gr, idx, to);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 0, 2'b00, 0, 0);
        rst_n = 1'b1;

        step(2'b00, 2'b00, 1); lit("idle_after_reset", 0, 2'b00, 0, 0);
        step(2'b01, 2'b00, 1); lit("single_req_ready", 1, 2'b01, 0, 0);
        step(2'b00, 2'b00, 1); lit("back_to_idle", 0, 2'b00, 0, 0);

        // round robin, last served = port 0
        step(2'b11, 2'b00, 1); lit("rr_1", 1, 2'b10, 1, 0);
        step(2'b11, 2'b00, 1); lit("rr_2", 1, 2'b01, 0, 0);
        step(2'b11, 2'b00, 1); lit("rr_3", 1, 2'b10, 1, 0);
        step(2'b11, 2'b00, 1); lit("rr_4", 1, 2'b01, 0, 0);
        step(2'b00, 2'b00, 1);

        // stall then release
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 2'b00, 0); lit("stall_hold", 0, 2'b10, 1, 0);
        end
        step(2'b10, 2'b00, 1); lit("stall_release", 1, 2'b10, 1, 0);
        step(2'b00, 2'b00, 1);

        // timeout: exactly STALL_MAX stall cycles
        for (int i = 0; i < STALL_MAX; i++) begin
            step(2'b01, 2'b00, 0); lit("timeout_stall", 0, 2'b01, 0, 0);
        end
        step(2'b01, 2'b00, 0); lit("timeout_own", 1, 2'b01, 0, 1);
        step(2'b01, 2'b00, 0); lit("timeout_restall", 0, 2'b01, 0, 0);

        // force preemption of stalled port 0
        step(2'b01, 2'b10, 0); lit("force_preempt", 1, 2'b10, 1, 0);
        step(2'b01, 2'b00, 1); lit("after_preempt", 1, 2'b01, 0, 0);
        step(2'b00, 2'b00, 1);

        // held force and force+request on both ports
        step(2'b00, 2'b01, 0); lit("force_held_1", 1, 2'b01, 0, 0);
        step(2'b00, 2'b01, 0); lit("force_held_2", 1, 2'b01, 0, 0);
        step(2'b11, 2'b11, 0); lit("force_lowest", 1, 2'b01, 0, 0);
        step(2'b00, 2'b00, 1);

        // withdrawal to another port, then to nobody
        step(2'b10, 2'b00, 0); lit("wd_stall_p1", 0, 2'b10, 1, 0);
        step(2'b01, 2'b00, 0); lit("wd_switch", 0, 2'b01, 0, 0);
        step(2'b01, 2'b00, 1); lit("wd_own_p0", 1, 2'b01, 0, 0);
        step(2'b00, 2'b00, 1);
        step(2'b10, 2'b00, 0); lit("wd2_stall", 0, 2'b10, 1, 0);
        step(2'b00, 2'b00, 0); lit("wd2_idle", 0, 2'b00, 0, 0);

        // asynchronous reset in the middle of a stall
        step(2'b10, 2'b00, 0); lit("pre_reset_stall", 0, 2'b10, 1, 0);
        #2 rst_n = 1'b0;
        #1 lit("async_reset", 0, 2'b00, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2'b11, 2'b00, 1); lit("post_reset_p0", 1, 2'b01, 0, 0);
        step(2'b00, 2'b00, 1); lit("final_idle", 0, 2'b00, 0, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_stall_arb.md
# cache_stall_arb

Registered, parametrised successor to the single-port cache stall logic. Arbitrates cache access among NPORT CPU-side requesters and tracks cache busy. Adds force override, round-robin fairness, a bounded stall counter with timeout escape, and request withdrawal. Sits between the core's load/store/fetch ports and the cache controller; drives the cache enable strobe and tells each port which one owns the access.

## Interface
Parameters:
- NPORT, 2, number of requesting ports (>= 2).
- STALL_MAX, 8, maximum consecutive stall cycles before forced enable; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  NPORT  per-port request; held by the port until it sees its grant bit with cache_enable.
- cpu_force  in  NPORT  per-port force; takes the cache regardless of busy.
- cache_busy_n  in  1  cache ready (1) / busy (0).
- cache_enable  out  1  registered; one cycle = one cache access by the granted port.
- grant  out  NPORT  registered one-hot owner; all zero in IDLE.
- grant_idx  out  $clog2(NPORT)  binary index of grant; 0 when grant is zero.
- stall_timeout  out  1  registered pulse; high in the OWN cycle entered through timeout.

## Operation
States: IDLE, STALL, OWN. Everything is computed from the inputs sampled at the edge; all outputs are registered.

Reset values:
- state=IDLE, grant=0, grant_idx=0, cache_enable=0, stall_timeout=0.
- rr_ptr=NPORT-1, so port 0 wins first; stall_cnt=0.

ARB rule, evaluated from IDLE and from OWN, first match wins:
1. Any cpu_force set: grant the lowest-index forced port and go to OWN.
2. Else any cpu_req set: pick the first requesting port strictly after rr_ptr, wrapping NPORT-1 to 0. Go to OWN if cache_busy_n=1; otherwise go to STALL with stall_cnt=0 and grant held on that port.
3. Else go to IDLE with grant=0.

In OWN:
- cache_enable=1.
- rr_ptr <= grant_idx at the end of the cycle, for forced and normal grants alike.
- Next state is decided by ARB, so back-to-back accesses are allowed.

In STALL, cache_enable=0 and transitions are checked in priority order:
1. Any cpu_force: preempt. Grant the lowest-index forced port and go to OWN. rr_ptr is unchanged until that OWN, so the stalled port remains next-in-line.
2. cpu_req[grant_idx]=0 (withdrawal): run ARB rule 2/3 immediately. A withdrawn port is never enabled.
3. cache_busy_n=1: go to OWN on the same port.
4. STALL_MAX!=0 and stall_cnt==STALL_MAX-1: go to OWN on the same port with stall_timeout=1. This enables the cache despite busy.
5. Else stay in STALL with stall_cnt+1. stall_cnt is $clog2(STALL_MAX)+1 bits wide and never wraps.

Other rules:
- A port requesting and forcing in the same cycle is treated as forced.
- cpu_force is level-sensitive: a force held across cycles yields consecutive OWN cycles for that port.
- stall_timeout is 0 in every cycle except the timeout-entered OWN cycle.
- Asserting rst_n low mid-transaction drops to the reset values immediately (asynchronously). No partial enable is emitted after reset release.

## Timing
- Latency with the cache ready: cpu_req sampled high at edge n gives cache_enable=1 and grant in cycle n+1, the cycle after edge n.
- Stall: enable follows 1 cycle after the edge at which cache_busy_n is sampled high.
- Maximum stall: STALL_MAX cycles in STALL, then OWN. With STALL_MAX=8, at most 8 stall cycles.
- Force while stalled: enable in the next cycle.
- grant and grant_idx are stable across STALL and change only on state transitions.
- cache_enable is never high with grant=0.

## Test plan
- Reset, single request, ready: NPORT=2, rst_n low then high. Expect outputs 0 and grant=0 after reset. cpu_req=01, busy_n=1 at edge 1 -> cycle 2: cache_enable=1, grant=01, grant_idx=0.
- Round robin under contention: cpu_req=11 held, busy_n=1 -> grants alternate 01,10,01,10 with cache_enable=1 every cycle.
- Stall then release: cpu_req=10, busy_n=0 for 3 edges then 1 -> 3 STALL cycles with enable=0 and grant=10, then one OWN cycle with stall_timeout=0.
- Timeout: STALL_MAX=8, cpu_req=01, busy_n=0 forever -> exactly 8 STALL cycles, then cache_enable=1 with stall_timeout=1 for 1 cycle.
- Force preemption: port 0 stalled with busy_n=0, cpu_force=10 for one cycle -> next cycle grant=10 with enable=1. Then force drops, busy_n=1 -> port 0 granted (rr_ptr=1).
- Withdrawal and mid-op reset: port 1 stalled, cpu_req goes 10->01 -> grant switches to 01 with no enable on port 1. In a later stall, rst_n pulses low -> all outputs 0 within the same cycle; after release, port 0 is granted first.
